// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage and
// the memory controller; misses issue a single word read and refill the line.
module icache_direct #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  flush,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  stallreq,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    input  logic [1:0]            mem_status
);

    localparam int unsigned LINES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_LO = 2 + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        RESP
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    flushed;
    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic [31:0]             data_mem [LINES];

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]     tag;
    logic                    cacheable;
    logic                    hit;
    logic                    done;
    logic                    fill;

    // Lookup fields always come from the latched request address
    assign idx       = req_addr[TAG_LO-1:2];
    assign tag       = req_addr[17:TAG_LO];
    assign cacheable = (req_addr[17:16] != 2'b11);
    assign hit       = valid[idx] && (tag_mem[idx] == tag) && cacheable;
    assign done      = (mem_status == 2'b10);
    assign fill      = rdy && (state == MISS) && done && cacheable;

    // Stall is raised in the same cycle a request is accepted
    assign stallreq = (state == LOOKUP) || (state == MISS) ||
                      ((state == IDLE) && if_req && !flush);

    // Tag/data storage is not reset; the valid bits guard it
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[idx] <= mem_data;
            tag_mem[idx]  <= tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            flushed    <= 1'b0;
            valid      <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (if_req && !flush) begin
                        req_addr <= if_addr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (hit) begin
                        inst       <= data_mem[idx];
                        inst_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= req_addr;
                        flushed  <= 1'b0;
                        state    <= MISS;
                    end
                end
                MISS: begin
                    // A redirect cannot cancel the bus read; remember it and drop the result
                    if (flush) begin
                        flushed <= 1'b1;
                    end
                    if (done) begin
                        mem_req <= 1'b0;
                        if (cacheable) begin
                            valid[idx] <= 1'b1;
                        end
                        if (flushed || flush) begin
                            state <= IDLE;
                        end else begin
                            inst       <= mem_data;
                            inst_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    inst_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
